// File: rtl/jtframe_frame_dump.sv
// jtframe_frame_dump
// Video capture engine. Counts frames on VS, captures a window of frames
// (START_FRAME, NFRAMES) into a small show-ahead FIFO and streams pixels out
// over valid/ready. Each entry is tagged with start-of-frame / start-of-line.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   pxl_cen                       pixel clock enable
//   HS, VS, LHBL, LVBL            sync (active-high) and blanking (active-low)
//   red, green, blue              pixel colour, CW bits each
//   frame_cnt                     completed-frame counter (VS rising edges)
//   dump_data/sof/sol/valid       FIFO head, zero while empty
//   dump_ready                    sink accepts head
//   busy, done, overflow          status; overflow is sticky
//   frame_crc, crc_stb            per-frame CRC-16-CCITT and its update strobe
//
// Optional feature macro: JTFRAME_DUMP_CRC_EN builds the CRC; otherwise
// frame_crc and crc_stb are tied to zero.
//
// state   | meaning
// --------+-------------------------------------------------------
// WAIT    | frame_cnt has not reached START_FRAME yet
// ARM     | start frame reached, waiting for the next VS edge
// CAPTURE | active pixels are written into the FIFO
// DONE    | NFRAMES frames captured; terminal until reset
module jtframe_frame_dump #(
  parameter int          CW          = 4,
  parameter int          FIFO_AW     = 4,
  parameter logic [31:0] START_FRAME = 32'd0,
  parameter int          NFRAMES     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pxl_cen,
  input  logic              HS,
  input  logic              VS,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic [CW-1:0]     red,
  input  logic [CW-1:0]     green,
  input  logic [CW-1:0]     blue,
  output logic [31:0]       frame_cnt,
  output logic [3*CW-1:0]   dump_data,
  output logic              dump_sof,
  output logic              dump_sol,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       frame_crc,
  output logic              crc_stb
);

  localparam int PW    = 3*CW;
  localparam int EW    = PW+2;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [31:0]      NF       = 32'(NFRAMES);
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_CAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]         st;
  logic [31:0]        frames_done;
  logic               vs_r, vs_rr, lhbl_r;
  logic               vs_edge, lhbl_rise;
  logic               sof_pend, sol_pend;
  logic               wr_req, full, push, pop;
  logic [EW-1:0]      entry, head;
  logic [EW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   cnt;

  // HS carries no information the blanking signals do not already give
  logic unused_hs;
  assign unused_hs = HS;

  assign vs_edge   = vs_r & ~vs_rr;
  assign lhbl_rise = LHBL & ~lhbl_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r      <= 1'b0;
      vs_rr     <= 1'b0;
      lhbl_r    <= 1'b0;
      frame_cnt <= 32'd0;
    end else begin
      vs_r   <= VS;
      vs_rr  <= vs_r;
      lhbl_r <= LHBL;
      if (vs_edge) frame_cnt <= frame_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_WAIT;
      frames_done <= 32'd0;
    end else begin
      case (st)
        ST_WAIT: if (frame_cnt == START_FRAME) st <= ST_ARM;
        ST_ARM:  if (vs_edge) st <= ST_CAP;
        ST_CAP: if (vs_edge) begin
          frames_done <= frames_done + 32'd1;
          if (NF != 32'd0 && frames_done + 32'd1 == NF) st <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // Fullness is judged on the count at the start of the cycle, so a
  // simultaneous pop never rescues a write into a full FIFO.
  assign wr_req = (st == ST_CAP) & pxl_cen & LHBL & LVBL;
  assign full   = (cnt == FULL_CNT);
  assign push   = wr_req & ~full;
  assign pop    = dump_valid & dump_ready;
  // A pixel on the very cycle LHBL rises is the first of its line.
  assign entry  = {sof_pend, sol_pend | lhbl_rise, red, green, blue};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sof_pend <= 1'b0;
      sol_pend <= 1'b0;
    end else begin
      if (vs_edge && (st == ST_ARM || st == ST_CAP)) sof_pend <= 1'b1;
      else if (push)                                 sof_pend <= 1'b0;
      if (push)           sol_pend <= 1'b0;
      else if (lhbl_rise) sol_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (FIFO_AW+1)'(1);
        2'b01:   cnt <= cnt - (FIFO_AW+1)'(1);
        default: ;
      endcase
      if (wr_req && full) overflow <= 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign dump_valid = (cnt != '0);
  assign dump_data  = dump_valid ? head[PW-1:0] : '0;
  assign dump_sol   = dump_valid & head[PW];
  assign dump_sof   = dump_valid & head[PW+1];
  assign busy       = (st == ST_CAP) | dump_valid;
  assign done       = (st == ST_DONE);

`ifdef JTFRAME_DUMP_CRC_EN
  logic [15:0] crc_run;

  // CRC-16-CCITT, MSB first, one pixel word per call
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [PW-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = PW-1; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_run   <= 16'hFFFF;
      frame_crc <= 16'd0;
      crc_stb   <= 1'b0;
    end else begin
      crc_stb <= 1'b0;
      if (push) crc_run <= crc_next(entry[PW+1] ? 16'hFFFF : crc_run, entry[PW-1:0]);
      if (vs_edge && st == ST_CAP) begin
        frame_crc <= crc_run;
        crc_stb   <= 1'b1;
      end
    end
  end
`else
  assign frame_crc = 16'd0;
  assign crc_stb   = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_frame_dump.sv
// Randomized bench for jtframe_frame_dump with a frame-level reference model.
module tb_jtframe_frame_dump;
  localparam int CW = 4, AW = 2, DEPTH = 4, S = 2, N = 2;

  logic clk = 1'b0;
  logic rst_n, pxl_cen, HS, VS, LHBL, LVBL, dump_ready;
  logic [CW-1:0] red, green, blue;
  logic [31:0] frame_cnt;
  logic [3*CW-1:0] dump_data;
  logic dump_sof, dump_sol, dump_valid, busy, done, overflow, crc_stb;
  logic [15:0] frame_crc;

  always #5 clk = ~clk;

  jtframe_frame_dump #(.CW(CW), .FIFO_AW(AW), .START_FRAME(32'(S)), .NFRAMES(N)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .HS(HS), .VS(VS), .LHBL(LHBL), .LVBL(LVBL),
    .red(red), .green(green), .blue(blue), .frame_cnt(frame_cnt), .dump_data(dump_data),
    .dump_sof(dump_sof), .dump_sol(dump_sol), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .busy(busy), .done(done), .overflow(overflow), .frame_crc(frame_crc), .crc_stb(crc_stb));

  int total = 0, bad = 0;
  logic [13:0] q[$];
  int vs_k, pop_cnt = 0, stb_cnt = 0;
  bit sof_m, sol_m, ovf_exp, toggle;
  logic [15:0] mcrc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] seed, input logic [11:0] px);
    int unsigned r;
    r = 32'(seed);
    for (int i = 11; i >= 0; i--) begin
      int unsigned fb;
      fb = ((r >> 15) & 32'd1) ^ 32'(px[i]);
      r = (r << 1) & 32'hFFFF;
      if (fb != 0) r = r ^ 32'h1021;
    end
    return 16'(r);
  endfunction

  function automatic bit in_win(input int k);
    return (k >= S+1) && (k <= S+N);
  endfunction

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (dump_valid && q.size() == 0) chk("valid_on_empty", 32'(dump_valid), 32'd0);
      if (dump_valid && dump_ready && q.size() != 0) begin
        chk("pop_data", {18'b0, dump_sof, dump_sol, dump_data}, {18'b0, q[0]});
        void'(q.pop_front());
        pop_cnt++;
      end
      if (crc_stb) stb_cnt++;
    end
    @(posedge clk);
    #1;
    if (toggle) dump_ready = ~dump_ready;
  endtask

  task automatic pix(input logic [11:0] rgb, input int gap);
    red = rgb[11:8]; green = rgb[7:4]; blue = rgb[3:0];
    pxl_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
    if (in_win(vs_k)) begin
      if (q.size() < DEPTH) begin
        q.push_back({sof_m, sol_m, rgb});
        mcrc = ref_crc(sof_m ? 16'hFFFF : mcrc, rgb);
        sof_m = 1'b0;
        sol_m = 1'b0;
      end else ovf_exp = 1'b1;
    end
    tick();
    pxl_cen = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic line(input int w, input int gap);
    LHBL = 1'b0; LVBL = 1'b1;
    tick(); tick();
    sol_m = 1'b1;
    for (int p = 0; p < w; p++) pix(12'($urandom_range(0, 4095)), gap);
    LHBL = 1'b0;
    tick();
  endtask

  task automatic frame(input int w, input int h, input int gap);
    for (int l = 0; l < h; l++) line(w, gap);
    LVBL = 1'b0;
    tick();
  endtask

  task automatic vs_pulse();
    int sb;
    bit ends;
    ends = in_win(vs_k);
    LHBL = 1'b0; LVBL = 1'b0;
    tick(); tick();
    sb = stb_cnt;
    VS = 1'b1;
    tick();
    chk("fcnt_hold", frame_cnt, 32'(vs_k));
    chk("done_hold", 32'(done), 32'(vs_k >= S+N+1));
    tick();
    vs_k++;
    chk("fcnt_inc", frame_cnt, 32'(vs_k));
    chk("done", 32'(done), 32'(vs_k >= S+N+1));
    tick(); tick();
    VS = 1'b0;
    tick();
`ifdef JTFRAME_DUMP_CRC_EN
    chk("crc_stb_cnt", 32'(stb_cnt - sb), 32'(ends));
    if (ends) chk("frame_crc", 32'(frame_crc), 32'(mcrc));
`else
    chk("crc_stb_cnt", 32'(stb_cnt - sb), 32'd0);
    chk("frame_crc_zero", 32'(frame_crc), 32'd0);
`endif
    sof_m = in_win(vs_k);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    tick(); tick();
    chk("valid_idle", 32'(dump_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'(in_win(vs_k)));
  endtask

  task automatic do_reset();
    toggle = 1'b0;
    rst_n = 1'b0;
    VS = 1'b0; HS = 1'b0; LHBL = 1'b0; LVBL = 1'b0; pxl_cen = 1'b0; dump_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_fcnt", frame_cnt, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_crc", {15'b0, crc_stb, frame_crc}, 32'd0);
    chk("rst_head", {18'b0, dump_sof, dump_sol, dump_data}, 32'd0);
    q.delete();
    vs_k = 0; sof_m = 1'b0; sol_m = 1'b0; ovf_exp = 1'b0; mcrc = 16'hFFFF;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int pb;
    red = '0; green = '0; blue = '0;

    // window capture with frames before the start frame and after done
    do_reset();
    dump_ready = 1'b1;
    vs_pulse(); frame(8, 4, 0);
    vs_pulse(); frame(8, 4, 0);
    vs_pulse();
    pb = pop_cnt;
    frame(8, 4, 0); drain(20);
    vs_pulse();
    frame(8, 4, 0); drain(20);
    vs_pulse(); drain(20);
    chk("window_pops", 32'(pop_cnt - pb), 32'd64);
    frame(8, 2, 0);
    chk("window_ovf", 32'(overflow), 32'(ovf_exp));

    // backpressure: ready toggles every cycle, sparse pixels
    do_reset();
    toggle = 1'b1;
    repeat (3) vs_pulse();
    pb = pop_cnt;
    frame(6, 3, 2); drain(50);
    vs_pulse();
    frame(5, 2, 2); drain(50);
    chk("bp_pops", 32'(pop_cnt - pb), 32'd28);
    chk("bp_ovf", 32'(overflow), 32'(ovf_exp));
    toggle = 1'b0;

    // overflow: sink stalled, more pixels than FIFO entries
    do_reset();
    repeat (3) vs_pulse();
    line(6, 0);
    chk("ovf_set", 32'(overflow), 32'(ovf_exp));
    chk("ovf_valid", 32'(dump_valid), 32'd1);
    chk("ovf_held", 32'(q.size()), 32'(DEPTH));
    pb = pop_cnt;
    dump_ready = 1'b1;
    drain(20);
    chk("ovf_pops", 32'(pop_cnt - pb), 32'(DEPTH));
    chk("ovf_sticky", 32'(overflow), 32'(ovf_exp));

    // reset in the middle of a capture with entries queued
    do_reset();
    repeat (3) vs_pulse();
    line(3, 0);
    tick();
    chk("mid_valid", 32'(dump_valid), 32'd1);
    do_reset();
    dump_ready = 1'b1;
    vs_pulse();
    frame(4, 2, 0);
    chk("mid_ovf", 32'(overflow), 32'd0);

    // single white pixel frame for the CRC
    do_reset();
    dump_ready = 1'b1;
    repeat (3) vs_pulse();
    LHBL = 1'b0; LVBL = 1'b1;
    tick(); tick();
    sol_m = 1'b1;
    pix(12'hFFF, 0);
    LHBL = 1'b0;
    tick();
    drain(10);
    vs_pulse();
`ifdef JTFRAME_DUMP_CRC_EN
    chk("crc_fff", 32'(frame_crc), 32'(ref_crc(16'hFFFF, 12'hFFF)));
`else
    chk("crc_off", 32'(frame_crc), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
